// File: rtl/button_conditioner.sv
// Push-button front end: each lane synchronises, debounces, edge-detects and
// optionally auto-repeats one raw KEY pin into clean active-high level/strobes.

module button_conditioner_lane #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel,
  output logic rpt
);

  localparam logic IDLE_RAW = (ACTIVE_LOW != 0);
  localparam int   CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int   HW       = $clog2(REPEAT_DELAY + REPEAT_PERIOD) + 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_FIRST = HW'(REPEAT_DELAY);
  localparam logic [HW-1:0] HOLD_WRAP  = HW'(REPEAT_DELAY + REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {S_RELEASED, S_ARMING, S_PRESSED, S_DISARMING} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   rel_q, rel_d;
  logic                   rpt_q, rpt_d;
  logic                   s;
  logic                   held_d;

  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], raw};

  // normalised sample: 1 means pressed regardless of pin polarity
  assign s = sync_q[SYNC_STAGES-1] ^ IDLE_RAW;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= {SYNC_STAGES{IDLE_RAW}};
      state_q <= S_RELEASED;
      cnt_q   <= '0;
      hold_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      rpt_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      rpt_q   <= rpt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RELEASED: begin
        if (s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = S_PRESSED;
          end else begin
            state_d = S_ARMING;
            cnt_d   = CW'(1);
          end
        end
      end
      S_ARMING: begin
        if (!s) begin
          state_d = S_RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PRESSED: begin
        if (!s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = S_RELEASED;
          end else begin
            state_d = S_DISARMING;
            cnt_d   = CW'(1);
          end
        end
      end
      S_DISARMING: begin
        if (s) begin
          state_d = S_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // Hold counter restarts only on a real press; a bounce back from DISARMING
  // keeps the button logically held, so repeat cadence continues.
  always_comb begin
    held_d  = (state_d == S_PRESSED) || (state_d == S_DISARMING);
    press_d = held_d && ((state_q == S_RELEASED) || (state_q == S_ARMING));
    rel_d   = !held_d && ((state_q == S_PRESSED) || (state_q == S_DISARMING));
    level_d = held_d;
    hold_d  = '0;
    rpt_d   = 1'b0;
    if ((REPEAT_DELAY > 0) && held_d && !press_d) begin
      hold_d = (hold_q == HOLD_WRAP) ? HOLD_FIRST : hold_q + 1'b1;
      rpt_d  = (hold_d == HOLD_FIRST);
    end
  end

  assign level = level_q;
  assign press = press_q;
  assign rel   = rel_q;
  assign rpt   = rpt_q;

endmodule

module button_conditioner #(
  parameter int CHANNELS        = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 1
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic [CHANNELS-1:0] btn_raw,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic [CHANNELS-1:0] btn_repeat
);

  button_conditioner_lane #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .ACTIVE_LOW     (ACTIVE_LOW),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_lane [CHANNELS-1:0] (
    .clk  (Clk),
    .rst_n(Reset_n),
    .raw  (btn_raw),
    .level(btn_level),
    .press(btn_press),
    .rel  (btn_release),
    .rpt  (btn_repeat)
  );

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: two instances (repeat off / repeat 8,3)
// share the same raw pins; edge k means the k-th posedge after the stimulus change.

module tb_button_conditioner;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b1;
  logic [1:0] btn_raw = 2'b11;
  logic [1:0] level, press, rel, rpt;
  logic [1:0] r_level, r_press, r_rel, r_rpt;
  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  button_conditioner #(
    .CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1),
    .REPEAT_DELAY(0), .REPEAT_PERIOD(1)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .btn_raw(btn_raw),
    .btn_level(level), .btn_press(press), .btn_release(rel), .btn_repeat(rpt)
  );

  button_conditioner #(
    .CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1),
    .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
  ) dut_rep (
    .Clk(Clk), .Reset_n(Reset_n), .btn_raw(btn_raw),
    .btn_level(r_level), .btn_press(r_press), .btn_release(r_rel), .btn_repeat(r_rpt)
  );

  // press and release must never coincide on a channel
  always @(negedge Clk) begin
    if (Reset_n === 1'b1) begin
      checks++;
      if (((press & rel) !== 2'b00) || ((r_press & r_rel) !== 2'b00)) begin
        errors++;
        $display("FAIL overlap: press=%b rel=%b r_press=%b r_rel=%b required no overlap",
                 press, rel, r_press, r_rel);
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    btn_raw = 2'b10;
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if ({level, press, rel, rpt, r_level, r_press, r_rel, r_rpt} !== 16'h0) begin
      errors++;
      $display("FAIL reset_async: got %h required 0000",
               {level, press, rel, rpt, r_level, r_press, r_rel, r_rpt});
    end
    repeat (3) step();
    checks++;
    if ({level, press, rel, rpt, r_level, r_press, r_rel, r_rpt} !== 16'h0) begin
      errors++;
      $display("FAIL reset_held: got %h required 0000",
               {level, press, rel, rpt, r_level, r_press, r_rel, r_rpt});
    end
  endtask

  task automatic test_hold_through_reset();
    Reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (level !== ((k >= 5) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL hold_level k=%0d: got %b required %b", k, level, (k >= 5) ? 2'b01 : 2'b00);
      end
      checks++;
      if (press !== ((k == 5) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL hold_press k=%0d: got %b required %b", k, press, (k == 5) ? 2'b01 : 2'b00);
      end
    end
  endtask

  task automatic test_glitch();
    for (int k = 0; k < 13; k++) begin
      btn_raw = (k < 3) ? 2'b11 : 2'b10;
      step();
      checks++;
      if ({level, press, rel} !== 6'b01_00_00) begin
        errors++;
        $display("FAIL glitch k=%0d: level/press/rel got %b required 010000", k, {level, press, rel});
      end
    end
  endtask

  task automatic test_release();
    btn_raw = 2'b11;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (rel !== ((k == 5) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL release k=%0d: got %b required %b", k, rel, (k == 5) ? 2'b01 : 2'b00);
      end
    end
    checks++;
    if (level !== 2'b00) begin
      errors++;
      $display("FAIL release_level: got %b required 00", level);
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 10; i++) begin
      btn_raw = {1'b1, (i % 2 == 1)};
      step();
      checks++;
      if ({level, press, rel} !== 6'b0) begin
        errors++;
        $display("FAIL bounce i=%0d: level/press/rel got %b required 000000", i, {level, press, rel});
      end
    end
    btn_raw = 2'b10;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if ({press, rel} !== ((k == 5) ? 4'b0100 : 4'b0000)) begin
        errors++;
        $display("FAIL bounce_settle k=%0d: press/rel got %b required %b", k, {press, rel},
                 (k == 5) ? 4'b0100 : 4'b0000);
      end
    end
  endtask

  task automatic test_repeat();
    btn_raw = 2'b00;
    for (int k = 0; k < 6; k++) step();
    checks++;
    if (r_press[1] !== 1'b1) begin
      errors++;
      $display("FAIL repeat_press: got %b required 1", r_press[1]);
    end
    for (int j = 1; j <= 26; j++) begin
      if (j == 15) btn_raw = 2'b10;
      step();
      checks++;
      if (r_rpt[1] !== ((j == 8) || (j == 11) || (j == 14) || (j == 17))) begin
        errors++;
        $display("FAIL repeat j=%0d: got %b required %b", j, r_rpt[1],
                 ((j == 8) || (j == 11) || (j == 14) || (j == 17)));
      end
      checks++;
      if (r_rel[1] !== (j == 20)) begin
        errors++;
        $display("FAIL repeat_release j=%0d: got %b required %b", j, r_rel[1], (j == 20));
      end
      checks++;
      if (rpt !== 2'b00) begin
        errors++;
        $display("FAIL repeat_disabled j=%0d: got %b required 00", j, rpt);
      end
    end
  endtask

  task automatic test_simultaneous();
    btn_raw = 2'b01;
    repeat (10) step();
    checks++;
    if (level !== 2'b10) begin
      errors++;
      $display("FAIL simul_setup: level got %b required 10", level);
    end
    btn_raw = 2'b10;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if ({press, rel} !== ((k == 5) ? 4'b0110 : 4'b0000)) begin
        errors++;
        $display("FAIL simul k=%0d: press/rel got %b required %b", k, {press, rel},
                 (k == 5) ? 4'b0110 : 4'b0000);
      end
    end
    checks++;
    if (level !== 2'b01) begin
      errors++;
      $display("FAIL simul_level: got %b required 01", level);
    end
  endtask

  task automatic test_reset_mid();
    btn_raw = 2'b01;
    repeat (10) step();
    btn_raw = 2'b00;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if ({level, press} !== 4'b1000) begin
        errors++;
        $display("FAIL arming k=%0d: level/press got %b required 1000", k, {level, press});
      end
    end
    Reset_n = 1'b0;
    #1;
    checks++;
    if ({level, press, rel, rpt, r_level, r_press, r_rel, r_rpt} !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid_async: got %h required 0000",
               {level, press, rel, rpt, r_level, r_press, r_rel, r_rpt});
    end
    repeat (2) step();
    Reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (press !== ((k == 5) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL reset_mid_press k=%0d: got %b required %b", k, press, (k == 5) ? 2'b11 : 2'b00);
      end
      checks++;
      if (level !== ((k >= 5) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL reset_mid_level k=%0d: got %b required %b", k, level, (k >= 5) ? 2'b11 : 2'b00);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hold_through_reset();
    test_glitch();
    test_release();
    test_bounce();
    test_repeat();
    test_simultaneous();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
